// File: rtl/tile_pixel_serializer_pkg.sv
// Shared constants and helpers for the tile pixel serializer.
// Tile geometry, last phase of a row, load-source selector and the one-step shift.
package tile_pixel_serializer_pkg;

  localparam int unsigned TileW     = 8;
  localparam logic [2:0]  PhaseLast = 3'd7;

  // Where the shifters get their data from at a load point
  typedef enum logic [1:0] {
    SrcZero   = 2'd0,
    SrcHold   = 2'd1,
    SrcBypass = 2'd2
  } load_src_e;

  // One-pixel shift: left pushes MSB out first, right pushes LSB out first
  function automatic logic [TileW-1:0] shift_once(input logic [TileW-1:0] v,
                                                  input logic              right);
    return right ? {1'b0, v[TileW-1:1]} : {v[TileW-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/tile_pixel_serializer_plane_shift8.sv
// One 8-bit parallel-in/serial-out plane shifter with load, shift enable and direction.
// Exposes its next-state value so the parent can register the post-edge pixel bit.
module tile_pixel_serializer_plane_shift8
  import tile_pixel_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             right,
  input  logic [TileW-1:0] load_val,
  output logic [TileW-1:0] next_val
);

  logic [TileW-1:0] shreg_q;

  // Load has priority over shift; otherwise hold
  always_comb begin
    next_val = shreg_q;
    if (load) begin
      next_val = load_val;
    end else if (shift) begin
      next_val = shift_once(shreg_q, right);
    end
  end

  // Shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= next_val;
    end
  end

endmodule

// File: rtl/tile_pixel_serializer.sv
// Tile pixel serializer: turns one fetched 8-pixel tile row (PLANES bitplanes) into a
// registered PLANES-bit pixel code per pixel-clock enable.
// Holds the phase counter, the row holding register, load/underrun logic and pix register.
// Optional feature macro: SERIALIZER_HFLIP_EN (defined: honour flip_d for horizontal flip;
// undefined: always MSB first, flip_d ignored).
module tile_pixel_serializer
  import tile_pixel_serializer_pkg::*;
#(
  parameter int unsigned PLANES      = 4,
  parameter int unsigned FETCH_PHASE = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_cen,
  input  logic                    sync_ld,
  input  logic                    data_we,
  input  logic [8*PLANES-1:0]     plane_d,
  input  logic                    flip_d,
  output logic                    fetch_req,
  output logic [PLANES-1:0]       pix,
  output logic                    underrun
);

  localparam logic [2:0] FetchPhase = 3'(FETCH_PHASE);

  logic [2:0]           phase_q, phase_d;
  logic                 hold_full_q, hold_full_d;
  logic [8*PLANES-1:0]  hold_data_q;
  logic [PLANES-1:0]    pix_q, pix_d;
  logic                 fetch_req_q, fetch_req_d;
  logic                 underrun_q, underrun_d;
  logic                 load, shift;
  load_src_e            load_src;
  logic [8*PLANES-1:0]  load_val;
  logic [TileW-1:0]     plane_next [PLANES];
  logic                 row_flip_q, row_flip_d;

  // A load happens at the end of a row or on an explicit restart
  always_comb begin
    load  = pix_cen & ((phase_q == PhaseLast) | sync_ld);
    shift = pix_cen & ~load;
  end

  // Same-cycle write bypasses the holding register; empty register loads zeros
  always_comb begin
    load_src = SrcZero;
    if (data_we) begin
      load_src = SrcBypass;
    end else if (hold_full_q) begin
      load_src = SrcHold;
    end
  end

  // Load data mux
  always_comb begin
    load_val = '0;
    unique case (load_src)
      SrcBypass: load_val = plane_d;
      SrcHold:   load_val = hold_data_q;
      default:   load_val = '0;
    endcase
  end

`ifdef SERIALIZER_HFLIP_EN
  logic hold_flip_q;
  logic load_flip;

  // Row direction follows the same source as the row data
  always_comb begin
    load_flip  = data_we ? flip_d : (hold_full_q & hold_flip_q);
    row_flip_d = load ? load_flip : row_flip_q;
  end

  // Flip bits of the holding register and of the row in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_flip_q <= 1'b0;
      row_flip_q  <= 1'b0;
    end else begin
      if (data_we) begin
        hold_flip_q <= flip_d;
      end
      row_flip_q <= row_flip_d;
    end
  end
`else
  logic unused_flip;
  assign unused_flip = flip_d;
  assign row_flip_q  = 1'b0;
  assign row_flip_d  = 1'b0;
`endif

  // Next phase, holding-register flag, fetch and underrun pulses
  always_comb begin
    phase_d = phase_q;
    if (pix_cen) begin
      phase_d = sync_ld ? 3'd0 : phase_q + 3'd1;
    end
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end else if (data_we) begin
      hold_full_d = 1'b1;
    end
    fetch_req_d = pix_cen & ~sync_ld & (phase_d == FetchPhase);
    underrun_d  = load & ~hold_full_q & ~data_we;
  end

  // Plane shifters, one per bitplane
  for (genvar k = 0; k < PLANES; k++) begin : g_plane
    tile_pixel_serializer_plane_shift8 u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .shift    (shift),
      .right    (row_flip_q),
      .load_val (load_val[8*k +: 8]),
      .next_val (plane_next[k])
    );
  end

  // Pixel code from the post-edge shifter state, direction of the post-edge row
  always_comb begin
    pix_d = pix_q;
    if (pix_cen) begin
      for (int k = 0; k < PLANES; k++) begin
        pix_d[k] = row_flip_d ? plane_next[k][0] : plane_next[k][TileW-1];
      end
    end
  end

  // Control and output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 3'd0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      pix_q       <= '0;
      fetch_req_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_full_q <= hold_full_d;
      if (data_we) begin
        hold_data_q <= plane_d;
      end
      pix_q       <= pix_d;
      fetch_req_q <= fetch_req_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pix       = pix_q;
  assign fetch_req = fetch_req_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_tile_pixel_serializer.sv
// Directed bench for tile_pixel_serializer: reset, basic row, underrun, bypass, hflip,
// enable gating and mid-row reset, all with hand-computed expectations.
module tb_tile_pixel_serializer;

  logic        clk;
  logic        rst_n;
  logic        pix_cen;
  logic        sync_ld;
  logic        data_we;
  logic [31:0] plane_d;
  logic        flip_d;
  logic        fetch_req;
  logic [3:0]  pix;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  tile_pixel_serializer #(
    .PLANES      (4),
    .FETCH_PHASE (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_cen   (pix_cen),
    .sync_ld   (sync_ld),
    .data_we   (data_we),
    .plane_d   (plane_d),
    .flip_d    (flip_d),
    .fetch_req (fetch_req),
    .pix       (pix),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pix_cen = 1'b0;
    sync_ld = 1'b0;
    data_we = 1'b0;
    plane_d = 32'h0;
    flip_d  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a5;
    logic [7:0] c3;
    int         n;
    a5 = 8'hA5;
    c3 = 8'hC3;

    // Reset held with pix_cen toggling
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_cen = i[0];
      step();
      check_eq("rst_pix", 32'(pix), 32'h0);
      check_eq("rst_fetch", 32'(fetch_req), 32'h0);
      check_eq("rst_underrun", 32'(underrun), 32'h0);
    end
    idle();
    rst_n = 1'b1;
    step();

    // Basic row: plane0 = A5, restart, pix_cen every cycle
    data_we = 1'b1;
    plane_d = 32'h0000_00A5;
    step();
    data_we = 1'b0;
    sync_ld = 1'b1;
    pix_cen = 1'b1;
    step();
    check_eq("row_px0", 32'(pix), 32'h1);
    check_eq("row_fetch0", 32'(fetch_req), 32'h0);
    sync_ld = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      check_eq("row_pix", 32'(pix), {31'h0, a5[7-i]});
      check_eq("row_fetch", 32'(fetch_req), (i == 3) ? 32'h1 : 32'h0);
      check_eq("row_underrun", 32'(underrun), 32'h0);
    end

    // Underrun: nothing written, phase-7 load finds the holding register empty
    step();
    check_eq("und_pix0", 32'(pix), 32'h0);
    check_eq("und_pulse", 32'(underrun), 32'h1);
    for (int i = 1; i < 8; i++) begin
      step();
      check_eq("und_pix", 32'(pix), 32'h0);
      check_eq("und_once", 32'(underrun), 32'h0);
      check_eq("und_fetch", 32'(fetch_req), (i == 3) ? 32'h1 : 32'h0);
    end

    // Bypass: write on the same cycle as the phase-7 load
    data_we = 1'b1;
    plane_d = 32'hFF00_0000;
    step();
    data_we = 1'b0;
    plane_d = 32'h0;
    check_eq("byp_pix0", 32'(pix), 32'h8);
    check_eq("byp_underrun", 32'(underrun), 32'h0);
    for (int i = 1; i < 8; i++) begin
      step();
      check_eq("byp_pix", 32'(pix), 32'h8);
      check_eq("byp_underrun_n", 32'(underrun), 32'h0);
    end
    // Holding register must have ended empty, so the next load underruns
    step();
    check_eq("byp_hold_empty", 32'(underrun), 32'h1);
    check_eq("byp_next_pix", 32'(pix), 32'h0);

    // Hflip row; the second write overwrites the first
    pix_cen = 1'b0;
    data_we = 1'b1;
    plane_d = 32'h0000_00FF;
    flip_d  = 1'b0;
    step();
    plane_d = 32'h0000_0001;
    flip_d  = 1'b1;
    step();
    idle();
    sync_ld = 1'b1;
    pix_cen = 1'b1;
    step();
    sync_ld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
`ifdef SERIALIZER_HFLIP_EN
      check_eq("flip_pix", 32'(pix), (i == 0) ? 32'h1 : 32'h0);
`else
      check_eq("noflip_pix", 32'(pix), (i == 7) ? 32'h1 : 32'h0);
`endif
    end

    // Enable gating: plane1 = C3, pix_cen every second cycle
    pix_cen = 1'b0;
    data_we = 1'b1;
    plane_d = 32'h0000_C300;
    step();
    data_we = 1'b0;
    plane_d = 32'h0;
    sync_ld = 1'b1;
    pix_cen = 1'b1;
    step();
    check_eq("gate_px0", 32'(pix), 32'h2);
    check_eq("gate_underrun0", 32'(underrun), 32'h0);
    sync_ld = 1'b0;
    for (int j = 0; j < 14; j++) begin
      pix_cen = j[0];
      step();
      n = (j + 1) / 2;
      check_eq("gate_pix", 32'(pix), {30'h0, c3[7-n], 1'b0});
      check_eq("gate_fetch", 32'(fetch_req), (j[0] && n == 3) ? 32'h1 : 32'h0);
    end

    // Mid-row reset discards the row and the holding register
    pix_cen = 1'b1;
    sync_ld = 1'b1;
    data_we = 1'b1;
    plane_d = 32'hFFFF_FFFF;
    step();
    check_eq("pre_rst_pix", 32'(pix), 32'hF);
    data_we = 1'b1;
    sync_ld = 1'b0;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_pix", 32'(pix), 32'h0);
    step();
    check_eq("mid_rst_pix", 32'(pix), 32'h0);
    check_eq("mid_rst_fetch", 32'(fetch_req), 32'h0);
    rst_n = 1'b1;
    step();
    pix_cen = 1'b1;
    sync_ld = 1'b1;
    step();
    idle();
    check_eq("post_rst_underrun", 32'(underrun), 32'h1);
    check_eq("post_rst_pix", 32'(pix), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
